// File: rtl/bus_arbiter.sv
// Z80 bus arbiter: lends the CPU bus to a DMA master through the BUSRQ/BUSACK
// handshake, muxes master signals toward memory, stretches DMA strobes with
// forced wait states and guarantees the CPU a minimum run between DMA grants.

package z80_bus_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        mreqn;
    logic        iorqn;
    logic        rdn;
    logic        wrn;
    logic        m1n;
    logic        rfshn;
    logic        inta;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;

endpackage

module bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MIN_CPU_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        dma_busrq,
  output logic        dma_busack,
  output logic        dma_wait,
  output logic        cpu_busrqn,
  input  logic        cpu_busackn,
  input  Z80MasterBus cpu_ibus,
  input  Z80MasterBus dma_ibus,
  output Z80MasterBus mem_obus,
  input  Z80SlaveBus  mem_ibus,
  output Z80SlaveBus  cpu_obus,
  output Z80SlaveBus  dma_obus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rdn_hist_q, rdn_hist_d;
  logic       wrn_hist_q, wrn_hist_d;
  logic       dma_busack_q, dma_busack_d;
  logic       cpu_busrqn_q, cpu_busrqn_d;
  logic       strobe_fall;
  Z80MasterBus cpu_quiet;

  // Ownership sequencing and the CPU fairness gap counter.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (dma_busrq) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (!dma_busrq)       state_d = ST_RELEASE;
          else if (!cpu_busackn) state_d = ST_GRANT;
        end
        ST_GRANT: begin
          if (!dma_busrq) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (cpu_busackn) begin
            if (MIN_CPU_GAP > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = 8'(MIN_CPU_GAP);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= 8'd1) begin
            state_d   = ST_IDLE;
            gap_cnt_d = 8'd0;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they flip on the entry edge.
  always_comb begin
    dma_busack_d = (state_d == ST_GRANT);
    cpu_busrqn_d = !((state_d == ST_REQ) || (state_d == ST_GRANT));
  end

  // Strobe falling-edge detection and the forced wait-state counter.
  always_comb begin
    strobe_fall = (rdn_hist_q & ~dma_ibus.rdn) | (wrn_hist_q & ~dma_ibus.wrn);
    rdn_hist_d  = rdn_hist_q;
    wrn_hist_d  = wrn_hist_q;
    wait_cnt_d  = wait_cnt_q;
    if (cen) begin
      rdn_hist_d = dma_ibus.rdn;
      wrn_hist_d = dma_ibus.wrn;
      if ((state_q == ST_GRANT) && (state_d == ST_GRANT)) begin
        if (strobe_fall)            wait_cnt_d = 4'(WAIT_STATES);
        else if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
      end else begin
        wait_cnt_d = 4'd0;
      end
    end
  end

  // State and counter registers with asynchronous reset to an idle, released bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= 8'd0;
      wait_cnt_q   <= 4'd0;
      rdn_hist_q   <= 1'b1;
      wrn_hist_q   <= 1'b1;
      dma_busack_q <= 1'b0;
      cpu_busrqn_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      rdn_hist_q   <= rdn_hist_d;
      wrn_hist_q   <= wrn_hist_d;
      dma_busack_q <= dma_busack_d;
      cpu_busrqn_q <= cpu_busrqn_d;
    end
  end

  // Master mux: DMA drives memory only while granted; during handover the CPU is silenced.
  always_comb begin
    cpu_quiet      = cpu_ibus;
    cpu_quiet.rdn  = 1'b1;
    cpu_quiet.wrn  = 1'b1;
    cpu_quiet.inta = 1'b0;
    case (state_q)
      ST_GRANT:   mem_obus = dma_ibus;
      ST_REQ:     mem_obus = cpu_quiet;
      ST_RELEASE: mem_obus = cpu_quiet;
      default:    mem_obus = cpu_ibus;
    endcase
  end

  // Slave responses: read data is shared, the CPU never sees waits while it is off the bus.
  always_comb begin
    cpu_obus.dslave = mem_ibus.dslave;
    cpu_obus.mwait  = (state_q == ST_GRANT) ? 1'b1 : mem_ibus.mwait;
    dma_obus.dslave = mem_ibus.dslave;
    dma_obus.mwait  = 1'b1;
  end

  assign dma_busack = dma_busack_q;
  assign cpu_busrqn = cpu_busrqn_q;
  assign dma_wait   = (state_q == ST_GRANT) && ((wait_cnt_q != 4'd0) || !mem_ibus.mwait);

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed handover scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural ownership model.

module tb_bus_arbiter;
  import z80_bus_pkg::*;

  localparam int WS  = 2;
  localparam int GAP = 4;

  localparam int P_IDLE    = 0;
  localparam int P_REQ     = 1;
  localparam int P_GRANT   = 2;
  localparam int P_RELEASE = 3;
  localparam int P_GAP     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        dma_busrq;
  logic        dma_busack;
  logic        dma_wait;
  logic        cpu_busrqn;
  logic        cpu_busackn;
  Z80MasterBus cpu_ibus;
  Z80MasterBus dma_ibus;
  Z80MasterBus mem_obus;
  Z80SlaveBus  mem_ibus;
  Z80SlaveBus  cpu_obus;
  Z80SlaveBus  dma_obus;

  int   total_count = 0;
  int   bad_count   = 0;
  logic check_en    = 1'b0;

  int   m_phase;
  int   m_gap_left;
  int   m_wait_left;
  logic m_prev_rdn;
  logic m_prev_wrn;

  bus_arbiter #(.WAIT_STATES(WS), .MIN_CPU_GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .dma_busrq   (dma_busrq),
    .dma_busack  (dma_busack),
    .dma_wait    (dma_wait),
    .cpu_busrqn  (cpu_busrqn),
    .cpu_busackn (cpu_busackn),
    .cpu_ibus    (cpu_ibus),
    .dma_ibus    (dma_ibus),
    .mem_obus    (mem_obus),
    .mem_ibus    (mem_ibus),
    .cpu_obus    (cpu_obus),
    .dma_obus    (dma_obus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Who owns the bus next, from the handshake rules.
  function automatic int next_phase(int ph, logic busrq, logic busackn, int gap_left);
    case (ph)
      P_IDLE:    return busrq ? P_REQ : P_IDLE;
      P_REQ:     return !busrq ? P_RELEASE : (!busackn ? P_GRANT : P_REQ);
      P_GRANT:   return busrq ? P_GRANT : P_RELEASE;
      P_RELEASE: return busackn ? ((GAP > 0) ? P_GAP : P_IDLE) : P_RELEASE;
      P_GAP:     return (gap_left <= 1) ? P_IDLE : P_GAP;
      default:   return P_IDLE;
    endcase
  endfunction

  // Remaining forced wait cycles after this enabled edge.
  function automatic int next_wait(int ph, int np, int w, logic fall);
    if (ph == P_GRANT && np == P_GRANT) return fall ? WS : ((w > 0) ? w - 1 : 0);
    return 0;
  endfunction

  function automatic Z80MasterBus exp_mem_obus();
    Z80MasterBus t;
    t = cpu_ibus;
    if (m_phase == P_GRANT) begin
      t = dma_ibus;
    end else if (m_phase == P_REQ || m_phase == P_RELEASE) begin
      t.rdn  = 1'b1;
      t.wrn  = 1'b1;
      t.inta = 1'b0;
    end
    return t;
  endfunction

  // Reference model advances on every enabled edge and resets asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase     <= P_IDLE;
      m_gap_left  <= 0;
      m_wait_left <= 0;
      m_prev_rdn  <= 1'b1;
      m_prev_wrn  <= 1'b1;
    end else if (cen) begin
      m_phase     <= next_phase(m_phase, dma_busrq, cpu_busackn, m_gap_left);
      m_gap_left  <= (next_phase(m_phase, dma_busrq, cpu_busackn, m_gap_left) == P_GAP)
                     ? ((m_phase == P_GAP) ? m_gap_left - 1 : GAP) : 0;
      m_wait_left <= next_wait(m_phase, next_phase(m_phase, dma_busrq, cpu_busackn, m_gap_left),
                               m_wait_left,
                               (m_prev_rdn && !dma_ibus.rdn) || (m_prev_wrn && !dma_ibus.wrn));
      m_prev_rdn  <= dma_ibus.rdn;
      m_prev_wrn  <= dma_ibus.wrn;
    end
  end

  // Every cycle, mid-period, compare all outputs with the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("dma_busack", 32'(dma_busack), 32'(m_phase == P_GRANT));
      checkOutput("cpu_busrqn", 32'(cpu_busrqn), 32'(!(m_phase == P_REQ || m_phase == P_GRANT)));
      checkOutput("dma_wait", 32'(dma_wait),
                  32'(m_phase == P_GRANT && (m_wait_left > 0 || !mem_ibus.mwait)));
      checkOutput("mem_obus", 32'(mem_obus), 32'(exp_mem_obus()));
      checkOutput("cpu_obus", 32'(cpu_obus),
                  32'({mem_ibus.dslave, (m_phase == P_GRANT) ? 1'b1 : mem_ibus.mwait}));
      checkOutput("dma_obus", 32'(dma_obus), 32'({mem_ibus.dslave, 1'b1}));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One cycle of random traffic with a loosely behaved CPU answering BUSRQ.
  task automatic applyStimulus();
    logic rd;
    logic wr;
    step();
    if (rst) rst = 1'b0;
    else if ($urandom_range(0, 399) == 0) rst = 1'b1;
    cen = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 7) == 0) dma_busrq = ~dma_busrq;
    if (!cpu_busrqn && $urandom_range(0, 2) == 0) cpu_busackn = 1'b0;
    else if (cpu_busrqn && $urandom_range(0, 2) == 0) cpu_busackn = 1'b1;
    cpu_ibus = Z80MasterBus'(31'($urandom));
    rd = dma_ibus.rdn;
    wr = dma_ibus.wrn;
    dma_ibus = Z80MasterBus'(31'($urandom));
    dma_ibus.rdn = ($urandom_range(0, 3) == 0) ? ~rd : rd;
    dma_ibus.wrn = ($urandom_range(0, 5) == 0) ? ~wr : wr;
    mem_ibus = Z80SlaveBus'({8'($urandom), ($urandom_range(0, 3) != 0)});
  endtask

  initial begin
    int cnt;
    rst         = 1'b1;
    cen         = 1'b1;
    dma_busrq   = 1'b0;
    cpu_busackn = 1'b1;
    cpu_ibus    = '{addr:16'h0, dout:8'h0, mreqn:1'b1, iorqn:1'b1, rdn:1'b1, wrn:1'b1,
                    m1n:1'b1, rfshn:1'b1, inta:1'b0};
    dma_ibus    = cpu_ibus;
    mem_ibus    = '{dslave:8'h5A, mwait:1'b1};
    step();
    step();
    check_en = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_busack", 32'(dma_busack), 32'd0);
    checkOutput("rst_busrqn", 32'(cpu_busrqn), 32'd1);
    checkOutput("rst_wait", 32'(dma_wait), 32'd0);
    step();
    rst = 1'b0;

    // Normal grant with the CPU acknowledging two cycles after the request.
    step();
    dma_busrq     = 1'b1;
    dma_ibus.addr = 16'hA5C3;
    cpu_ibus.addr = 16'h1234;
    cpu_ibus.rdn  = 1'b0;
    @(negedge clk);
    checkOutput("idle_busrqn", 32'(cpu_busrqn), 32'd1);
    checkOutput("idle_addr", 32'(mem_obus.addr), 32'h1234);
    step();
    @(negedge clk);
    checkOutput("req_busrqn", 32'(cpu_busrqn), 32'd0);
    checkOutput("req_rdn_forced", 32'(mem_obus.rdn), 32'd1);
    step();
    step();
    cpu_busackn = 1'b0;
    step();
    @(negedge clk);
    checkOutput("grant_busack", 32'(dma_busack), 32'd1);
    checkOutput("grant_addr", 32'(mem_obus.addr), 32'hA5C3);

    // Forced wait states on a DMA read strobe.
    step();
    dma_ibus.rdn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dma_wait) cnt++;
    end
    checkOutput("ws_count", 32'(cnt), 32'(WS));
    step();
    dma_ibus.rdn = 1'b1;

    // Fairness gap: request dropped and immediately reasserted.
    step();
    dma_busrq = 1'b0;
    step();
    dma_busrq   = 1'b1;
    cpu_busackn = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_busrqn) cnt++;
      else break;
    end
    // Four gap cycles plus the idle cycle that accepts the new request.
    checkOutput("gap_hold", 32'(cnt), 32'(GAP + 1));

    // Abort while still requesting: no grant, BUSRQ released on the next edge.
    step();
    dma_busrq = 1'b0;
    step();
    @(negedge clk);
    checkOutput("abort_busrqn", 32'(cpu_busrqn), 32'd1);
    checkOutput("abort_busack", 32'(dma_busack), 32'd0);

    // Clock-enable freeze in the middle of the gap.
    @(posedge clk);
    #2;
    cen       = 1'b0;
    dma_busrq = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    cen = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_busrqn) cnt++;
      else break;
    end
    checkOutput("cen_gap_hold", 32'(cnt), 32'(GAP + 1));

    // Asynchronous reset during a grant with one wait cycle left.
    step();
    cpu_busackn = 1'b0;
    step();
    dma_ibus.wrn = 1'b0;
    step();
    step();
    #1;
    checkOutput("pre_rst_wait", 32'(dma_wait), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_busack", 32'(dma_busack), 32'd0);
    checkOutput("async_busrqn", 32'(cpu_busrqn), 32'd1);
    checkOutput("async_wait", 32'(dma_wait), 32'd0);
    step();
    rst          = 1'b0;
    dma_busrq    = 1'b0;
    cpu_busackn  = 1'b1;
    dma_ibus.wrn = 1'b1;

    // First request after reset is served without a gap.
    step();
    dma_busrq = 1'b1;
    step();
    @(negedge clk);
    checkOutput("post_rst_req", 32'(cpu_busrqn), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) applyStimulus();
    step();
    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
